regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_bypass.sv | 27 ++
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default sizes.
package regfile_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port output mux: stored value, same-cycle write data (port 1 first), or forced zero.
module regfile_bypass #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            ready,
    input  logic [AW-1:0]   ra,
    input  logic [XLEN-1:0] stored,
    input  logic            act0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            act1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    output logic [XLEN-1:0] rd
);

    always_comb begin
        rd = stored;
        if (act0 && (wa0 == ra)) rd = wd0;
        if (act1 && (wa1 == ra)) rd = wd1;
        // Sweep in progress, or the hardwired zero register, overrides any bypass.
        if (!ready || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with pending scoreboard and a zero-sweep clear FSM.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we0,
    input  logic                we1,
    input  logic [AW-1:0]       wa0,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd0,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      pend,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_req,
    output logic                busy
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   cnt, cnt_nx;
    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] pending;

    logic ready, commit, act0, act1, wr0, wr1, rsv_ok;

    assign ready  = (state == READY);
    assign busy   = !ready;
    // A clear request in READY discards everything else presented that cycle.
    assign commit = ready && !clr_req && rst_n;
    assign act0   = commit && we0;
    assign act1   = commit && we1;
    assign wr0    = act0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1    = act1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign rsv_ok = commit && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            SWEEP: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) state_nx = READY;
            end
            READY: begin
                if (clr_req) begin
                    state_nx = SWEEP;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = SWEEP;
        endcase
    end

    // Array has no reset; it is only ever cleared by the sweep. Port 1 writes last so it wins.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
        end
    end

    // Reservation is applied after write clears so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (!ready) begin
            pending[cnt] <= 1'b0;
        end else begin
            if (wr0)    pending[wa0]      <= 1'b0;
            if (wr1)    pending[wa1]      <= 1'b0;
            if (rsv_ok) pending[rsv_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        assign ra_k    = ra[k*AW +: AW];
        assign pend[k] = ready && pending[ra_k];

        regfile_bypass #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_bypass (
            .ready  (ready),
            .ra     (ra_k),
            .stored (mem[ra_k]),
            .act0   (act0),
            .wa0    (wa0),
            .wd0    (wd0),
            .act1   (act1),
            .wa1    (wa1),
            .wd1    (wd1),
            .rd     (rd[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  pend;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        clr_req;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .we1      (we1),
        .wa0      (wa0),
        .wa1      (wa1),
        .wd0      (wd0),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .pend     (pend),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with busy high, starting just after the edge that entered SWEEP.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0; clr_req = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #2;
            chk({tag, "_rd0"}, rd[31:0], 32'h0);
            chk({tag, "_rd1"}, rd[63:32], 32'h0);
            chk({tag, "_pend"}, {30'h0, pend}, 32'h0);
            tick();
        end
    endtask

    initial begin
        rst_n = 0; idle();
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra = 0; rsv_addr = 0;

        // Reset and initial sweep
        tick();
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_rd", rd[31:0], 32'h0);
        chk("rst_pend", {30'h0, pend}, 32'h0);
        rst_n = 1;
        count_busy(n);
        chk("rst_sweep_len", n, 32);
        chk("ready_busy", {31'h0, busy}, 32'h0);
        check_all_zero("init");

        // Dual write to the same address: port 1 wins, also on bypass
        we0 = 1; wa0 = 5; wd0 = 32'hAAAA0000;
        we1 = 1; wa1 = 5; wd1 = 32'h5555FFFF;
        ra = {5'd0, 5'd5};
        #2;
        chk("dual_bypass", rd[31:0], 32'h5555FFFF);
        tick(); idle();
        #2;
        chk("dual_stored", rd[31:0], 32'h5555FFFF);

        // Bypass on port 0, zero register on port 1
        tick();
        we0 = 1; wa0 = 7; wd0 = 32'h12345678;
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
        ra = {5'd0, 5'd7};
        #2;
        chk("byp_rd0", rd[31:0], 32'h12345678);
        chk("byp_zero", rd[63:32], 32'h0);
        tick(); idle();
        #2;
        chk("byp_stored", rd[31:0], 32'h12345678);
        chk("zero_stored", rd[63:32], 32'h0);

        // Scoreboard
        tick();
        rsv_en = 1; rsv_addr = 3; ra = {5'd3, 5'd3};
        #2;
        chk("pend_not_bypassed", {30'h0, pend}, 32'h0);
        tick(); idle();
        #2;
        chk("pend_set", {30'h0, pend}, 32'h3);
        tick();
        rsv_en = 1; rsv_addr = 3; we0 = 1; wa0 = 3; wd0 = 32'h33;
        tick(); idle();
        #2;
        chk("pend_rsv_wins", {31'h0, pend[0]}, 32'h1);
        chk("rsv_write_data", rd[31:0], 32'h33);
        tick();
        we1 = 1; wa1 = 3; wd1 = 32'h44;
        tick(); idle();
        #2;
        chk("pend_clr", {31'h0, pend[0]}, 32'h0);
        chk("wr1_data", rd[31:0], 32'h44);
        tick();
        rsv_en = 1; rsv_addr = 0; ra = {5'd3, 5'd0};
        tick(); idle();
        #2;
        chk("pend_zero_reg", {31'h0, pend[0]}, 32'h0);

        // Fill 1..31, then clear while writing 9
        for (int i = 1; i < 32; i++) begin
            tick();
            we0 = 1; wa0 = 5'(i); wd0 = 32'h10000000 + i;
        end
        tick(); idle();
        rsv_en = 1; rsv_addr = 12;
        tick(); idle();
        ra = {5'd12, 5'd9};
        #2;
        chk("fill_r9", rd[31:0], 32'h10000009);
        chk("fill_pend12", {31'h0, pend[1]}, 32'h1);
        tick();
        clr_req = 1; we0 = 1; wa0 = 9; wd0 = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 9;
        tick();
        #2;
        chk("sweep_rd", rd[31:0], 32'h0);
        chk("sweep_pend", {30'h0, pend}, 32'h0);
        count_busy(n);
        idle();
        chk("clr_sweep_len", n, 32);
        check_all_zero("clr");

        // Mid-sweep reset restarts the sweep
        clr_req = 1;
        tick(); idle();
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 0;
        tick();
        rst_n = 1;
        count_busy(n);
        chk("mid_rst_sweep_len", n, 32);
        chk("mid_ready", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
